// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared constants for the bit-serial magnitude comparator.
package serial_magnitude_comparator_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned STATE_W       = 2;

  // FSM encoding; 2'd3 is unreachable and recovers to idle
  localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] S_SCAN = 2'd1;
  localparam logic [STATE_W-1:0] S_DONE = 2'd2;

endpackage

// File: rtl/serial_magnitude_comparator_bit_compare_cell.sv
// One-bit combinational relation cell: flags x>y and x<y for single bits.
module bit_compare_cell
  import serial_magnitude_comparator_pkg::*;
(
  input  logic x,
  input  logic y,
  output logic gt,
  output logic lt
);

  // Bit relation; both low means the bits are equal
  always_comb begin
    gt = x & ~y;
    lt = ~x & y;
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// MSB-first bit-serial unsigned comparator; stops at the first differing bit.
module serial_magnitude_comparator
  import serial_magnitude_comparator_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  logic [STATE_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               gt_q, gt_d;
  logic               eq_q, eq_d;
  logic               lt_q, lt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cell_gt_c, cell_lt_c;

  // Relation of the currently selected operand bit pair
  bit_compare_cell u_cell (
    .x  (a_q[idx_q]),
    .y  (b_q[idx_q]),
    .gt (cell_gt_c),
    .lt (cell_lt_c)
  );

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: scan ends on the first differing bit or after bit 0
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_SCAN;
      S_SCAN: begin
        if (cell_gt_c || cell_lt_c || (idx_q == '0)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values; flags hold until the next accept
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    idx_d = idx_q;
    gt_d  = gt_q;
    eq_d  = eq_q;
    lt_d  = lt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          idx_d = IDX_W'(WIDTH - 1);
          gt_d  = 1'b0;
          eq_d  = 1'b0;
          lt_d  = 1'b0;
        end
      end
      S_SCAN: begin
        if (cell_gt_c) begin
          gt_d = 1'b1;
        end else if (cell_lt_c) begin
          lt_d = 1'b1;
        end else if (idx_q == '0) begin
          eq_d = 1'b1;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      default: ;
    endcase
    busy_d = (state_d == S_SCAN) || (state_d == S_DONE);
    done_d = (state_d == S_DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign gt   = gt_q;
  assign eq   = eq_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench with a transaction-level reference model and per-cycle compare.
module tb_serial_magnitude_comparator;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy, done, gt, eq, lt;

  int vectors     = 0;
  int miscompares = 0;
  bit cmp_en      = 1'b0;

  serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .gt    (gt),
    .eq    (eq),
    .lt    (lt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Edges spent scanning: WIDTH - k for first difference at bit k, WIDTH if equal
  function automatic int scan_edges(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int unsigned d;
    d = 32'(x ^ y);
    if (d == 0) return WIDTH;
    return WIDTH - ($clog2(d + 1) - 1);
  endfunction

  // Reference model: a transaction with a countdown to its result
  logic             m_busy = 1'b0, m_done = 1'b0;
  logic             m_gt = 1'b0, m_eq = 1'b0, m_lt = 1'b0;
  logic [WIDTH-1:0] m_ra = '0, m_rb = '0;
  int               m_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0;
      m_gt <= 1'b0; m_eq <= 1'b0; m_lt <= 1'b0;
      m_cnt <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_gt   <= (m_ra > m_rb);
        m_eq   <= (m_ra == m_rb);
        m_lt   <= (m_ra < m_rb);
      end
      m_cnt <= m_cnt - 1;
    end else if (start) begin
      m_busy <= 1'b1;
      m_ra   <= a;
      m_rb   <= b;
      m_cnt  <= scan_edges(a, b);
      m_gt <= 1'b0; m_eq <= 1'b0; m_lt <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_busy", 32'(busy), 32'(m_busy));
      check("model_done", 32'(done), 32'(m_done));
      check("model_gt",   32'(gt),   32'(m_gt));
      check("model_eq",   32'(eq),   32'(m_eq));
      check("model_lt",   32'(lt),   32'(m_lt));
    end
  end

  // lat counts edges from the accepting edge (inclusive) until done is seen
  task automatic wait_done(inout int lat);
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, output int lat);
    start = 1'b1; a = ta; b = tb;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    wait_done(lat);
  endtask

  task automatic check_pulse_end(input string name);
    @(posedge clk); #1;
    check(name, 32'(done), 32'd0);
  endtask

  task automatic check_flags(input string name, input logic eg, input logic ee, input logic el);
    check({name, "_gt"}, 32'(gt), 32'(eg));
    check({name, "_eq"}, 32'(eq), 32'(ee));
    check({name, "_lt"}, 32'(lt), 32'(el));
  endtask

  initial begin
    int lat;
    int n_done;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 cmp_en = 1'b1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: MSB differs
    run(8'hA5, 8'h25, lat);
    check("t1_latency", 32'(lat), 32'd2);
    check_flags("t1", 1'b1, 1'b0, 1'b0);
    check_pulse_end("t1_done_width");
    check("t1_busy_after", 32'(busy), 32'd0);

    // 2: equal words, flags held while idle
    run(8'h3C, 8'h3C, lat);
    check("t2_latency", 32'(lat), 32'd9);
    check_flags("t2", 1'b0, 1'b1, 1'b0);
    check_pulse_end("t2_done_width");
    repeat (5) begin
      @(posedge clk); #1;
      check_flags("t2_hold", 1'b0, 1'b1, 1'b0);
    end

    // 3: LSB decides, then MSB decides
    run(8'h10, 8'h11, lat);
    check("t3a_latency", 32'(lat), 32'd9);
    check_flags("t3a", 1'b0, 1'b0, 1'b1);
    check_pulse_end("t3a_done_width");
    run(8'hFF, 8'h00, lat);
    check("t3b_latency", 32'(lat), 32'd2);
    check_flags("t3b", 1'b1, 1'b0, 1'b0);
    check_pulse_end("t3b_done_width");

    // 4: start held, operands change after acceptance
    start = 1'b1; a = 8'h80; b = 8'h7F;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      a = 8'(i * 37 + 5);
      b = 8'(i * 91 + 3);
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          check("t4_first_latency", 32'(i + 1), 32'd2);
          check_flags("t4_first", 1'b1, 1'b0, 1'b0);
        end
      end
      if (i == 2) check("t4_idle_gap", 32'(busy), 32'd0);
      if (i == 3) check("t4_second_accept", 32'(busy), 32'd1);
    end
    start = 1'b0;
    for (int i = 0; i < 20 && busy; i++) begin
      @(posedge clk); #1;
    end
    check("t4_drain", 32'(busy), 32'd0);

    // 5: reset mid-scan
    start = 1'b1; a = 8'h01; b = 8'h02;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("t5_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check_flags("t5_rst", 1'b0, 1'b0, 1'b0);
    run(8'h02, 8'h01, lat);
    check("t5_latency", 32'(lat), 32'd8);
    check_flags("t5", 1'b1, 1'b0, 1'b0);
    check_pulse_end("t5_done_width");

    // 6: start during DONE ignored, then accepted in IDLE
    run(8'h05, 8'h07, lat);
    check("t6a_latency", 32'(lat), 32'd8);
    check_flags("t6a", 1'b0, 1'b0, 1'b1);
    start = 1'b1; a = 8'hFF; b = 8'h00;
    @(posedge clk); #1;
    check("t6_done_width", 32'(done), 32'd0);
    check("t6_ignored_busy", 32'(busy), 32'd0);
    check_flags("t6_ignored", 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    check("t6_accept_busy", 32'(busy), 32'd1);
    check_flags("t6_cleared", 1'b0, 1'b0, 1'b0);
    lat = 1;
    wait_done(lat);
    check("t6b_latency", 32'(lat), 32'd2);
    check_flags("t6b", 1'b1, 1'b0, 1'b0);
    check_pulse_end("t6b_done_width");

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
